// File: rtl/traffic_light_monitor.sv
// Passive checker for the four-way intersection light bus.
// Decodes the N/S/E/W light codes into an eight-step phase, locks onto the
// rotation, and checks encoding legality, phase order and per-phase dwell.
// Errors are reported as sticky flags plus a one-cycle strobe; completed
// rotations are counted with saturation.
// Optional build macro TRAFFIC_LIGHT_MONITOR_COVER_EN adds the phase_seen
// coverage bitmask output.
module traffic_light_monitor #(
  parameter int unsigned GREEN_CYC  = 8,
  parameter int unsigned YELLOW_CYC = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned RND_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       north,
  input  logic [2:0]       south,
  input  logic [2:0]       east,
  input  logic [2:0]       west,
  input  logic             err_clr,
  output logic             locked,
  output logic [2:0]       phase,
  output logic [RND_W-1:0] rounds,
  output logic             err_illegal,
  output logic             err_seq,
  output logic             err_dwell,
`ifdef TRAFFIC_LIGHT_MONITOR_COVER_EN
  output logic [7:0]       phase_seen,
`endif
  output logic             err_pulse
);

  localparam logic [2:0] CodeGreen  = 3'b001;
  localparam logic [2:0] CodeYellow = 3'b010;
  localparam logic [2:0] CodeRed    = 3'b100;

  localparam logic [CNT_W-1:0] GreenReq  = CNT_W'(GREEN_CYC);
  localparam logic [CNT_W-1:0] YellowReq = CNT_W'(YELLOW_CYC);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [0:0] {StUnsync, StTrack} state_e;

  state_e           state_q, state_d;
  logic             locked_q, locked_d;
  logic [2:0]       phase_q, phase_d;
  logic             prev_vld_q, prev_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RND_W-1:0] rounds_q, rounds_d;
  logic [2:0]       flags_q, flags_d;
  logic             pulse_q, pulse_d;

  logic             smp_legal;
  logic [2:0]       smp_phase;
  logic [2:0]       phase_inc;
  logic [CNT_W-1:0] req;
  logic [CNT_W-1:0] req_p1;
  logic             set_ill;
  logic             set_seq;
  logic             set_dwell;
  logic [2:0]       set_vec;

`ifdef TRAFFIC_LIGHT_MONITOR_COVER_EN
  logic [7:0]       seen_q, seen_d;
  logic [7:0]       seen_set;
`endif

  function automatic logic code_ok(input logic [2:0] c);
    return (c == CodeGreen) || (c == CodeYellow) || (c == CodeRed);
  endfunction

  // Decode the current light sample into legality and phase number.
  always_comb begin
    logic nr_n, nr_s, nr_e, nr_w;
    logic all_ok;
    nr_n      = (north != CodeRed);
    nr_s      = (south != CodeRed);
    nr_e      = (east != CodeRed);
    nr_w      = (west != CodeRed);
    all_ok    = code_ok(north) && code_ok(south) && code_ok(east) && code_ok(west);
    smp_phase = 3'd0;
    // Exactly one non-red direction; all-red is illegal too.
    smp_legal = all_ok && ({2'b00, nr_n} + {2'b00, nr_s} + {2'b00, nr_e} + {2'b00, nr_w}
                           == 3'd1);
    if (nr_n) begin
      smp_phase = {2'd0, north == CodeYellow};
    end else if (nr_s) begin
      smp_phase = {2'd1, south == CodeYellow};
    end else if (nr_e) begin
      smp_phase = {2'd2, east == CodeYellow};
    end else if (nr_w) begin
      smp_phase = {2'd3, west == CodeYellow};
    end
  end

  // Required dwell of the phase currently being tracked (odd phases are yellow).
  always_comb begin
    req       = phase_q[0] ? YellowReq : GreenReq;
    req_p1    = req + CntOne;
    phase_inc = phase_q + 3'd1;
  end

  // Next-state logic for the sync FSM, dwell counter and rotation counter.
  always_comb begin
    state_d    = state_q;
    locked_d   = locked_q;
    phase_d    = phase_q;
    prev_vld_d = prev_vld_q;
    cnt_d      = cnt_q;
    rounds_d   = rounds_q;
    set_ill    = 1'b0;
    set_seq    = 1'b0;
    set_dwell  = 1'b0;
`ifdef TRAFFIC_LIGHT_MONITOR_COVER_EN
    seen_set   = 8'h00;
`endif
    unique case (state_q)
      StUnsync: begin
        if (smp_legal) begin
          phase_d    = smp_phase;
          prev_vld_d = 1'b1;
          // The very first legal sample after reset has nothing to compare to.
          if (prev_vld_q && (smp_phase != phase_q)) begin
            state_d  = StTrack;
            locked_d = 1'b1;
            cnt_d    = CntOne;
          end
        end
      end
      StTrack: begin
        if (!smp_legal) begin
          set_ill  = 1'b1;
          locked_d = 1'b0;
          state_d  = StUnsync;
        end else if (smp_phase == phase_q) begin
          if (cnt_q != req_p1) begin
            cnt_d = cnt_q + CntOne;
          end
          // Crossing into req+1 flags the overstay exactly once.
          if (cnt_q == req) begin
            set_dwell = 1'b1;
          end
        end else if (smp_phase == phase_inc) begin
          // A saturated count was already flagged when it overstayed.
          if ((cnt_q != req) && (cnt_q != req_p1)) begin
            set_dwell = 1'b1;
          end
          cnt_d   = CntOne;
          phase_d = smp_phase;
          if ((phase_q == 3'd7) && !(&rounds_q)) begin
            rounds_d = rounds_q + RND_W'(1);
          end
`ifdef TRAFFIC_LIGHT_MONITOR_COVER_EN
          seen_set[smp_phase] = 1'b1;
`endif
        end else begin
          set_seq  = 1'b1;
          locked_d = 1'b0;
          state_d  = StUnsync;
          phase_d  = smp_phase;
        end
      end
      default: begin
        state_d = StUnsync;
      end
    endcase
  end

  // Sticky error flags; a new error on the clearing edge takes priority.
  always_comb begin
    set_vec = {set_ill, set_seq, set_dwell};
    flags_d = (err_clr ? 3'b000 : flags_q) | set_vec;
    pulse_d = |(set_vec & (~flags_q | {3{err_clr}}));
`ifdef TRAFFIC_LIGHT_MONITOR_COVER_EN
    seen_d  = (err_clr ? 8'h00 : seen_q) | seen_set;
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StUnsync;
      locked_q   <= 1'b0;
      phase_q    <= 3'd0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
      rounds_q   <= '0;
      flags_q    <= 3'b000;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      locked_q   <= locked_d;
      phase_q    <= phase_d;
      prev_vld_q <= prev_vld_d;
      cnt_q      <= cnt_d;
      rounds_q   <= rounds_d;
      flags_q    <= flags_d;
      pulse_q    <= pulse_d;
    end
  end

`ifdef TRAFFIC_LIGHT_MONITOR_COVER_EN
  // Coverage bitmask register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_q <= 8'h00;
    end else begin
      seen_q <= seen_d;
    end
  end

  assign phase_seen = seen_q;
`endif

  assign locked      = locked_q;
  assign phase       = phase_q;
  assign rounds      = rounds_q;
  assign err_illegal = flags_q[2];
  assign err_seq     = flags_q[1];
  assign err_dwell   = flags_q[0];
  assign err_pulse   = pulse_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor.
module tb_traffic_light_monitor;

  logic        clk;
  logic        reset;
  logic [2:0]  north, south, east, west;
  logic        err_clr;
  logic        locked;
  logic [2:0]  phase;
  logic [15:0] rounds;
  logic        err_illegal, err_seq, err_dwell, err_pulse;
`ifdef TRAFFIC_LIGHT_MONITOR_COVER_EN
  logic [7:0]  phase_seen;
`endif

  int n_cmp = 0;
  int n_err = 0;

  traffic_light_monitor #(
    .GREEN_CYC (8),
    .YELLOW_CYC(4),
    .CNT_W     (4),
    .RND_W     (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .north      (north),
    .south      (south),
    .east       (east),
    .west       (west),
    .err_clr    (err_clr),
    .locked     (locked),
    .phase      (phase),
    .rounds     (rounds),
    .err_illegal(err_illegal),
    .err_seq    (err_seq),
    .err_dwell  (err_dwell),
`ifdef TRAFFIC_LIGHT_MONITOR_COVER_EN
    .phase_seen (phase_seen),
`endif
    .err_pulse  (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present one raw sample; return 1ns after the edge that captured it.
  task automatic drive_raw(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e,
                           input logic [2:0] w);
    north = n;
    south = s;
    east  = e;
    west  = w;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_phase(input int p, input int cycles);
    logic [2:0] c[4];
    for (int i = 0; i < 4; i++) c[i] = 3'b100;
    c[p / 2] = (p % 2 == 1) ? 3'b010 : 3'b001;
    for (int k = 0; k < cycles; k++) drive_raw(c[0], c[1], c[2], c[3]);
  endtask

  task automatic check_errs(input string tag, input logic [2:0] exp_flags, input logic exp_pls);
    check_eq({tag, "_ill"}, {31'd0, err_illegal}, {31'd0, exp_flags[2]});
    check_eq({tag, "_seq"}, {31'd0, err_seq}, {31'd0, exp_flags[1]});
    check_eq({tag, "_dwell"}, {31'd0, err_dwell}, {31'd0, exp_flags[0]});
    check_eq({tag, "_pulse"}, {31'd0, err_pulse}, {31'd0, exp_pls});
  endtask

  initial begin
    reset   = 1'b0;
    err_clr = 1'b0;
    north   = 3'b001;
    south   = 3'b100;
    east    = 3'b100;
    west    = 3'b100;
    #2;
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    check_eq("rst_phase", {29'd0, phase}, 32'd0);
    check_eq("rst_rounds", {16'd0, rounds}, 32'd0);
    check_errs("rst", 3'b000, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Nominal: three rotations starting on N green.
    drive_phase(0, 8);
    check_eq("pre_lock", {31'd0, locked}, 32'd0);
    check_eq("pre_lock_phase", {29'd0, phase}, 32'd0);
    drive_phase(1, 1);
    check_eq("lock", {31'd0, locked}, 32'd1);
    check_eq("lock_phase", {29'd0, phase}, 32'd1);
    drive_phase(1, 3);
    for (int p = 2; p < 8; p++) drive_phase(p, (p % 2 == 1) ? 4 : 8);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 8; p++) drive_phase(p, (p % 2 == 1) ? 4 : 8);
    check_eq("nom_rounds", {16'd0, rounds}, 32'd2);
    check_eq("nom_locked", {31'd0, locked}, 32'd1);
    check_eq("nom_phase", {29'd0, phase}, 32'd7);
    check_errs("nom", 3'b000, 1'b0);

    // Stretch N green to nine samples.
    drive_phase(0, 8);
    check_eq("str_rounds", {16'd0, rounds}, 32'd3);
    check_errs("str8", 3'b000, 1'b0);
    drive_phase(0, 1);
    check_errs("str9", 3'b001, 1'b1);
    check_eq("str_locked", {31'd0, locked}, 32'd1);
    drive_phase(1, 1);
    check_errs("str_after", 3'b001, 1'b0);
    drive_phase(1, 3);

    // Out-of-order jump 1 -> 4.
    drive_phase(4, 1);
    check_errs("jump", 3'b011, 1'b1);
    check_eq("jump_locked", {31'd0, locked}, 32'd0);
    check_eq("jump_phase", {29'd0, phase}, 32'd4);
    drive_phase(4, 7);
    check_eq("jump_unsync", {31'd0, locked}, 32'd0);
    drive_phase(5, 1);
    check_eq("relock", {31'd0, locked}, 32'd1);
    check_eq("relock_phase", {29'd0, phase}, 32'd5);

    // Illegal north code while locked.
    drive_raw(3'b011, 3'b100, 3'b010, 3'b100);
    check_errs("ill_trk", 3'b111, 1'b1);
    check_eq("ill_locked", {31'd0, locked}, 32'd0);
    check_eq("ill_phase", {29'd0, phase}, 32'd5);
    drive_phase(5, 1);
    check_eq("ill_stay", {31'd0, locked}, 32'd0);

    // Clear with no error, then illegal in UNSYNC raises nothing.
    err_clr = 1'b1;
    drive_phase(5, 1);
    err_clr = 1'b0;
    check_errs("clr", 3'b000, 1'b0);
    check_eq("clr_phase", {29'd0, phase}, 32'd5);
    drive_raw(3'b011, 3'b100, 3'b010, 3'b100);
    check_errs("ill_uns", 3'b000, 1'b0);
    check_eq("ill_uns_phase", {29'd0, phase}, 32'd5);
    drive_phase(6, 1);
    check_eq("relock2", {31'd0, locked}, 32'd1);
    check_eq("relock2_phase", {29'd0, phase}, 32'd6);
    drive_phase(6, 2);

    // Clear on the same edge as an illegal sample: the error wins.
    err_clr = 1'b1;
    drive_raw(3'b011, 3'b100, 3'b100, 3'b001);
    err_clr = 1'b0;
    check_errs("clr_ill", 3'b100, 1'b1);
    check_eq("clr_ill_locked", {31'd0, locked}, 32'd0);
    check_eq("clr_ill_phase", {29'd0, phase}, 32'd6);

    // Mid-phase reset, then a clean rotation after release.
    drive_phase(6, 3);
    #3;
    reset = 1'b0;
    #1;
    check_eq("mrst_locked", {31'd0, locked}, 32'd0);
    check_eq("mrst_phase", {29'd0, phase}, 32'd0);
    check_eq("mrst_rounds", {16'd0, rounds}, 32'd0);
    check_errs("mrst", 3'b000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int p = 0; p < 8; p++) drive_phase(p, (p % 2 == 1) ? 4 : 8);
    drive_phase(0, 1);
    check_eq("post_locked", {31'd0, locked}, 32'd1);
    check_eq("post_rounds", {16'd0, rounds}, 32'd1);
    check_eq("post_phase", {29'd0, phase}, 32'd0);
    check_errs("post", 3'b000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
